// File: rtl/seq_step_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_step_if
// Purpose  : Bundles the control, monitored-input, step-table configuration
//            and status signals of seq_step_fsm.
// Modports : master - drives start/abort/in_vec/cfg_*, observes status
//            slave  - the sequencer side (inputs in, status out)
// Signals  : start, abort, in_vec[IN_W], cfg_we, cfg_addr[STEP_W],
//            cfg_pattern[IN_W], cfg_mask[IN_W], cfg_dwell[CNT_W],
//            busy, done, fault, step[STEP_W], fail_step[STEP_W],
//            retry_cnt[8]
// Revision : 1.0 - initial release
// ============================================================================
interface seq_step_if #(
  parameter int IN_W   = 4,
  parameter int CNT_W  = 16,
  parameter int STEP_W = 4
);
  logic              start;
  logic              abort;
  logic [IN_W-1:0]   in_vec;
  logic              cfg_we;
  logic [STEP_W-1:0] cfg_addr;
  logic [IN_W-1:0]   cfg_pattern;
  logic [IN_W-1:0]   cfg_mask;
  logic [CNT_W-1:0]  cfg_dwell;
  logic              busy;
  logic              done;
  logic              fault;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] fail_step;
  logic [7:0]        retry_cnt;

  modport master (
    output start, abort, in_vec, cfg_we, cfg_addr, cfg_pattern, cfg_mask,
           cfg_dwell,
    input  busy, done, fault, step, fail_step, retry_cnt
  );

  modport slave (
    input  start, abort, in_vec, cfg_we, cfg_addr, cfg_pattern, cfg_mask,
           cfg_dwell,
    output busy, done, fault, step, fail_step, retry_cnt
  );
endinterface
`default_nettype wire

// File: rtl/seq_step_fsm.sv
`default_nettype none
// ============================================================================
// Module   : seq_step_fsm
// Purpose  : Programmable step sequencer. Each step waits a configured dwell
//            time, then checks the monitored inputs against a masked pattern.
//            All steps matching -> DONE; a miss either restarts from step 0
//            (bounded by MAX_RETRY) or faults immediately.
// Ports    : clk   - sole clock, rising edge
//            reset - synchronous, active-low
//            bus   - seq_step_if.slave (control, cfg table write, status)
// Revision : 1.0 - initial release
// ============================================================================
module seq_step_fsm #(
  parameter int IN_W            = 4,
  parameter int NUM_STEPS       = 13,
  parameter int CNT_W           = 16,
  parameter int RESTART_ON_MISS = 1,
  parameter int MAX_RETRY       = 3
) (
  input wire logic  clk,
  input wire logic  reset,
  seq_step_if.slave bus
);
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [7:0]        C_MAX_RETRY = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DWELL = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] r_fail_step;
  logic [7:0]        r_retry;
  logic              r_busy;
  logic              r_done;
  logic              r_fault;

  logic [IN_W-1:0]   r_pattern [NUM_STEPS];
  logic [IN_W-1:0]   r_mask    [NUM_STEPS];
  logic [CNT_W-1:0]  r_dwell   [NUM_STEPS];

  logic [IN_W-1:0]   w_pattern;
  logic [IN_W-1:0]   w_mask;
  logic [CNT_W-1:0]  w_dwell_eff;
  logic              w_dwell_done;
  logic              w_match;
  logic [7:0]        w_retry_inc;

  // A dwell of 0 behaves like 1: every step spends at least one cycle in DWELL.
  assign w_pattern    = r_pattern[r_step];
  assign w_mask       = r_mask[r_step];
  assign w_dwell_eff  = (r_dwell[r_step] == '0) ? CNT_W'(1) : r_dwell[r_step];
  assign w_dwell_done = (r_cnt >= (w_dwell_eff - CNT_W'(1)));
  assign w_match      = ((bus.in_vec ^ w_pattern) & w_mask) == '0;
  assign w_retry_inc  = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;

  // Step table: writable only while idle so a running sequence never sees
  // its own parameters change underneath it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_pattern[i] <= '0;
        r_mask[i]    <= '0;
        r_dwell[i]   <= '0;
      end
    end else if (bus.cfg_we && (r_state == S_IDLE) &&
                 (32'(bus.cfg_addr) < NUM_STEPS)) begin
      r_pattern[bus.cfg_addr] <= bus.cfg_pattern;
      r_mask[bus.cfg_addr]    <= bus.cfg_mask;
      r_dwell[bus.cfg_addr]   <= bus.cfg_dwell;
    end
  end

  // Sequencer FSM; status flags are registered together with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_step      <= '0;
      r_fail_step <= '0;
      r_retry     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else if (bus.abort) begin
      // fail_step and retry_cnt deliberately hold for post-mortem inspection.
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (bus.start) begin
            r_state <= S_DWELL;
            r_cnt   <= '0;
            r_step  <= '0;
            r_retry <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
          end
        end

        S_DWELL: begin
          if (w_dwell_done) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_CHECK: begin
          r_cnt <= '0;
          if (w_match) begin
            if (r_step == C_LAST_STEP) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DWELL;
              r_step  <= r_step + STEP_W'(1);
            end
          end else begin
            r_retry <= w_retry_inc;
            if ((RESTART_ON_MISS != 0) && (w_retry_inc < C_MAX_RETRY)) begin
              r_state <= S_DWELL;
              r_step  <= '0;
            end else begin
              r_state     <= S_FAULT;
              r_fail_step <= r_step;
              r_busy      <= 1'b0;
              r_fault     <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.fault     = r_fault;
  assign bus.step      = r_step;
  assign bus.fail_step = r_fail_step;
  assign bus.retry_cnt = r_retry;
endmodule
`default_nettype wire

// File: doc/seq_step_fsm.md
SEQ_STEP_FSM -- requirements
Module: seq_step_fsm

Interface
REQ-001 Parameter IN_W, default 4, width of the monitored input vector.
REQ-002 Parameter NUM_STEPS, default 13, number of sequence steps (2..64).
REQ-003 Parameter CNT_W, default 16, width of per-step dwell counter.
REQ-004 Parameter RESTART_ON_MISS, default 1: 1 = a miss returns to step 0; 0 = a miss faults immediately.
REQ-005 Parameter MAX_RETRY, default 3, misses tolerated before FAULT when RESTART_ON_MISS=1 (1..255).
REQ-006 Derived STEP_W = clog2(NUM_STEPS), minimum 1.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
REQ-009 start  input  1  begin sequence at step 0.
REQ-010 abort  input  1  cancel sequence, return to IDLE.
REQ-011 in_vec  input  IN_W  monitored inputs, synchronous to clk.
REQ-012 cfg_we  input  1  step-table write strobe.
REQ-013 cfg_addr  input  STEP_W  step index written.
REQ-014 cfg_pattern / cfg_mask  input  IN_W each  expected value / compare mask for that step.
REQ-015 cfg_dwell  input  CNT_W  cycles to wait before that step's check.
REQ-016 busy  output  1  high in DWELL or CHECK.
REQ-017 done  output  1  high in DONE.
REQ-018 fault  output  1  high in FAULT.
REQ-019 step  output  STEP_W  current step index.
REQ-020 fail_step  output  STEP_W  step at which FAULT was entered.
REQ-021 retry_cnt  output  8  misses counted in the current run.

Function
REQ-022 States SHALL be IDLE, DWELL, CHECK, DONE, FAULT; one-hot or binary is implementation choice.
REQ-023 Table write: when cfg_we=1, state=IDLE and cfg_addr<NUM_STEPS, entry cfg_addr takes pattern/mask/dwell on that edge; otherwise the write is ignored.
REQ-024 IDLE + start=1 -> DWELL next cycle, step=0, dwell counter=0, retry_cnt=0.
REQ-025 DWELL lasts max(dwell[step],1) cycles, then CHECK.
REQ-026 CHECK lasts exactly 1 cycle; match = ((in_vec ^ pattern[step]) & mask[step]) == 0, evaluated on in_vec during that cycle; mask=0 always matches.
REQ-027 CHECK match, step<NUM_STEPS-1 -> DWELL, step+1, counter cleared.
REQ-028 CHECK match, step=NUM_STEPS-1 -> DONE; step holds NUM_STEPS-1.
REQ-029 CHECK miss, RESTART_ON_MISS=1: retry_cnt+1 (saturating at 255); if new value >= MAX_RETRY -> FAULT, else DWELL with step=0.
REQ-030 CHECK miss, RESTART_ON_MISS=0 -> FAULT.
REQ-031 On FAULT entry, fail_step SHALL capture the step that missed.
REQ-032 DONE and FAULT hold until start (-> DWELL, step 0, flags and retry_cnt cleared) or abort (-> IDLE).
REQ-033 abort=1 SHALL take priority over start, match and dwell expiry in every state; next state IDLE, step=0; fail_step and retry_cnt hold.
REQ-034 start while in DWELL or CHECK SHALL be ignored.
REQ-035 Minimum run time for all-dwell-1 table: 2*NUM_STEPS cycles from start edge to done=1.

Reset
REQ-036 reset=0 SHALL force IDLE, step=0, fail_step=0, retry_cnt=0, busy=done=fault=0, counter=0, all table entries pattern=0, mask=0, dwell=0.
REQ-037 reset=0 mid-sequence SHALL abort identically regardless of state; reset has priority over abort, start and cfg_we.

Verification
REQ-038 NUM_STEPS=4, dwells 2,3,1,5, masks 4'hF, in_vec matching each pattern -> done=1 exactly 15 cycles after start edge, step=3.
REQ-039 RESTART_ON_MISS=0, step 2 pattern 4'hA, in_vec=4'h5 at its CHECK -> fault=1 next cycle, fail_step=2, busy=0.
REQ-040 RESTART_ON_MISS=1, MAX_RETRY=3, step 1 always mismatching -> step returns to 0 twice, fault on third miss, retry_cnt=3, fail_step=1.
REQ-041 abort and start asserted together during DWELL at step 2 -> IDLE next cycle, step=0, busy=0; cfg_we during DWELL leaves table unchanged (readback by subsequent run).
REQ-042 reset=0 for one cycle while in CHECK -> all outputs 0 next cycle; following run with unprogrammed table (mask 0, dwell 0) -> done after 2*NUM_STEPS cycles.
